// File: rtl/tpu_job_scheduler.sv
// tpu_job_scheduler: buffers GEMM job descriptors in a small FIFO, launches them one at a time
// on the TPU (in_valid pulse, busy start/finish tracking) and returns a tagged completion
// record per job. Zero-dimension jobs are rejected without touching the TPU.
// Optional feature: define TPU_SCHED_WATCHDOG_EN to add a TIMEOUT_W-bit busy watchdog.
module tpu_job_scheduler #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TIMEOUT_W = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [9:0]               cmd_K,
    input  logic [12:0]              cmd_M,
    input  logic [8:0]               cmd_N,
    input  logic [31:0]              cmd_offset,
    input  logic [3:0]               cmd_tag,
    input  logic                     flush,
    output logic                     tpu_in_valid,
    output logic [9:0]               tpu_K,
    output logic [12:0]              tpu_M,
    output logic [8:0]               tpu_N,
    output logic [31:0]              tpu_offset,
    input  logic                     tpu_busy,
    output logic                     done_valid,
    input  logic                     done_ready,
    output logic [3:0]               done_tag,
    output logic                     done_err,
    output logic [$clog2(DEPTH):0]   queue_level,
    output logic                     idle,
    output logic [15:0]              jobs_done
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitStart,
        StWaitDone,
        StReport,
        StGap
    } state_e;

    state_e state_q;

    logic [9:0]  fifo_k   [DEPTH];
    logic [12:0] fifo_m   [DEPTH];
    logic [8:0]  fifo_n   [DEPTH];
    logic [31:0] fifo_off [DEPTH];
    logic [3:0]  fifo_tag [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    // Low while in reset so cmd_ready reads 0 until the first clock after release.
    logic             ready_en_q;

    logic       job_zero_q;
    logic [3:0] job_tag_q;

    logic full, empty, push, pop, head_zero;

`ifdef TPU_SCHED_WATCHDOG_EN
    logic [TIMEOUT_W-1:0] wd_cnt_q;
    logic                 wd_expired;
    assign wd_expired = (wd_cnt_q == {TIMEOUT_W{1'b1}});
`else
    logic unused_timeout_w;
    assign unused_timeout_w = ^TIMEOUT_W;
`endif

    assign full      = (count_q == DEPTH_CNT);
    assign empty     = (count_q == '0);
    assign cmd_ready = ready_en_q && !full && !flush;
    assign push      = cmd_valid && cmd_ready;
    // Flush wins over a pop so the queue is empty the cycle after flush.
    assign pop       = (state_q == StIdle) && !empty && !flush;
    assign head_zero = (fifo_k[rd_ptr_q] == '0) || (fifo_m[rd_ptr_q] == '0) ||
                       (fifo_n[rd_ptr_q] == '0);

    assign queue_level = count_q;
    assign idle        = empty && (state_q == StIdle);

    // FIFO payload storage; written on push, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_k[wr_ptr_q]   <= cmd_K;
            fifo_m[wr_ptr_q]   <= cmd_M;
            fifo_n[wr_ptr_q]   <= cmd_N;
            fifo_off[wr_ptr_q] <= cmd_offset;
            fifo_tag[wr_ptr_q] <= cmd_tag;
        end
    end

    // FIFO pointers and occupancy; flush discards queued entries only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                if (push && !pop) begin
                    count_q <= count_q + (PTR_W + 1)'(1);
                end else if (!push && pop) begin
                    count_q <= count_q - (PTR_W + 1)'(1);
                end
            end
        end
    end

    // Job FSM with registered TPU launch and completion-record outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            tpu_in_valid <= 1'b0;
            tpu_K        <= '0;
            tpu_M        <= '0;
            tpu_N        <= '0;
            tpu_offset   <= '0;
            done_valid   <= 1'b0;
            done_tag     <= '0;
            done_err     <= 1'b0;
            jobs_done    <= '0;
            job_zero_q   <= 1'b0;
            job_tag_q    <= '0;
`ifdef TPU_SCHED_WATCHDOG_EN
            wd_cnt_q     <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (pop) begin
                        job_tag_q  <= fifo_tag[rd_ptr_q];
                        job_zero_q <= head_zero;
                        // Rejected jobs leave the TPU-facing fields untouched.
                        if (!head_zero) begin
                            tpu_K        <= fifo_k[rd_ptr_q];
                            tpu_M        <= fifo_m[rd_ptr_q];
                            tpu_N        <= fifo_n[rd_ptr_q];
                            tpu_offset   <= fifo_off[rd_ptr_q];
                            tpu_in_valid <= 1'b1;
                        end
                        state_q <= StLaunch;
                    end
                end
                StLaunch: begin
                    tpu_in_valid <= 1'b0;
                    if (job_zero_q) begin
                        done_valid <= 1'b1;
                        done_tag   <= job_tag_q;
                        done_err   <= 1'b1;
                        state_q    <= StReport;
                    end else begin
`ifdef TPU_SCHED_WATCHDOG_EN
                        wd_cnt_q <= '0;
`endif
                        state_q  <= StWaitStart;
                    end
                end
                StWaitStart: begin
`ifdef TPU_SCHED_WATCHDOG_EN
                    if (tpu_busy) begin
                        wd_cnt_q <= wd_cnt_q + TIMEOUT_W'(1);
                        state_q  <= StWaitDone;
                    end else if (wd_expired) begin
                        done_valid <= 1'b1;
                        done_tag   <= job_tag_q;
                        done_err   <= 1'b1;
                        state_q    <= StReport;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + TIMEOUT_W'(1);
                    end
`else
                    if (tpu_busy) state_q <= StWaitDone;
`endif
                end
                StWaitDone: begin
                    if (!tpu_busy) begin
                        done_valid <= 1'b1;
                        done_tag   <= job_tag_q;
                        done_err   <= 1'b0;
                        state_q    <= StReport;
`ifdef TPU_SCHED_WATCHDOG_EN
                    end else if (wd_expired) begin
                        done_valid <= 1'b1;
                        done_tag   <= job_tag_q;
                        done_err   <= 1'b1;
                        state_q    <= StReport;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + TIMEOUT_W'(1);
`endif
                    end
                end
                StReport: begin
                    if (done_ready) begin
                        done_valid <= 1'b0;
                        jobs_done  <= jobs_done + 16'd1;
                        state_q    <= StGap;
                    end
                end
                StGap: begin
`ifdef TPU_SCHED_WATCHDOG_EN
                    // A timed-out TPU may still be busy; hold off until it lets go.
                    if (!tpu_busy) state_q <= StIdle;
`else
                    state_q <= StIdle;
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_job_scheduler.sv
// Directed bench for tpu_job_scheduler with a simple TPU busy model.
module tb_tpu_job_scheduler;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_K;
    logic [12:0] cmd_M;
    logic [8:0]  cmd_N;
    logic [31:0] cmd_offset;
    logic [3:0]  cmd_tag;
    logic        flush;
    logic        tpu_in_valid;
    logic [9:0]  tpu_K;
    logic [12:0] tpu_M;
    logic [8:0]  tpu_N;
    logic [31:0] tpu_offset;
    logic        tpu_busy;
    logic        done_valid;
    logic        done_ready;
    logic [3:0]  done_tag;
    logic        done_err;
    logic [$clog2(DEPTH):0] queue_level;
    logic        idle;
    logic [15:0] jobs_done;

    logic model_busy;
    logic force_busy;
    assign tpu_busy = model_busy | force_busy;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    int cyc      = 0;
    int busy_len = 40;
    int busy_cnt = 0;
    int launches = 0;
    int fall_cyc = -1;
    int last_gap = -1;
    int launch_k[$];

    int exp_k[6] = '{16, 1, 2, 3, 4, 5};
    int l0;
    int l1;

    always #5 clk = ~clk;

    tpu_job_scheduler #(
        .DEPTH     (DEPTH),
        .TIMEOUT_W (6)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_K        (cmd_K),
        .cmd_M        (cmd_M),
        .cmd_N        (cmd_N),
        .cmd_offset   (cmd_offset),
        .cmd_tag      (cmd_tag),
        .flush        (flush),
        .tpu_in_valid (tpu_in_valid),
        .tpu_K        (tpu_K),
        .tpu_M        (tpu_M),
        .tpu_N        (tpu_N),
        .tpu_offset   (tpu_offset),
        .tpu_busy     (tpu_busy),
        .done_valid   (done_valid),
        .done_ready   (done_ready),
        .done_tag     (done_tag),
        .done_err     (done_err),
        .queue_level  (queue_level),
        .idle         (idle),
        .jobs_done    (jobs_done)
    );

    // TPU model: busy rises the cycle after in_valid and stays high busy_len cycles.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            model_busy <= 1'b0;
            busy_cnt   <= 0;
        end else if (tpu_in_valid) begin
            model_busy <= 1'b1;
            busy_cnt   <= busy_len - 1;
            launches   <= launches + 1;
            launch_k.push_back(int'(tpu_K));
            if (fall_cyc >= 0) last_gap <= cyc - fall_cyc;
        end else if (model_busy) begin
            if (busy_cnt == 0) begin
                model_busy <= 1'b0;
                fall_cyc   <= cyc + 1;
            end else begin
                busy_cnt <= busy_cnt - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int k, input int m, input int n, input int off, input int tag);
        cmd_valid  = 1'b1;
        cmd_K      = 10'(k);
        cmd_M      = 13'(m);
        cmd_N      = 9'(n);
        cmd_offset = 32'(off);
        cmd_tag    = 4'(tag);
    endtask

    initial begin
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_K      = '0;
        cmd_M      = '0;
        cmd_N      = '0;
        cmd_offset = '0;
        cmd_tag    = '0;
        flush      = 1'b0;
        done_ready = 1'b0;
        force_busy = 1'b0;

        // Reset state
        tick(3);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_in_valid", 32'(tpu_in_valid), 32'd0);
        chk("rst_tpu_K", 32'(tpu_K), 32'd0);
        chk("rst_done_valid", 32'(done_valid), 32'd0);
        chk("rst_level", 32'(queue_level), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_jobs_done", 32'(jobs_done), 32'd0);
        rst_n = 1'b1;
        tick(1);
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);

        // Single job, launch latency and completion
        set_cmd(16, 8, 8, 128, 3);
        tick(1);
        cmd_valid = 1'b0;
        chk("single_level", 32'(queue_level), 32'd1);
        chk("single_no_early_launch", 32'(tpu_in_valid), 32'd0);
        tick(1);
        chk("single_in_valid", 32'(tpu_in_valid), 32'd1);
        chk("single_K", 32'(tpu_K), 32'd16);
        chk("single_M", 32'(tpu_M), 32'd8);
        chk("single_N", 32'(tpu_N), 32'd8);
        chk("single_offset", tpu_offset, 32'd128);
        tick(1);
        chk("single_pulse_width", 32'(tpu_in_valid), 32'd0);
        chk("single_busy", 32'(tpu_busy), 32'd1);
        tick(40);
        chk("single_busy_fell", 32'(tpu_busy), 32'd0);
        chk("single_no_done_yet", 32'(done_valid), 32'd0);
        tick(1);
        chk("single_done_valid", 32'(done_valid), 32'd1);
        chk("single_done_tag", 32'(done_tag), 32'd3);
        chk("single_done_err", 32'(done_err), 32'd0);
        chk("single_fields_stable", 32'(tpu_K), 32'd16);
        chk("single_jobs_before_hs", 32'(jobs_done), 32'd0);
        done_ready = 1'b1;
        tick(1);
        chk("single_done_cleared", 32'(done_valid), 32'd0);
        chk("single_jobs_done", 32'(jobs_done), 32'd1);
        tick(1);
        chk("single_idle", 32'(idle), 32'd1);
        chk("single_launches", 32'(launches), 32'd1);

        // Five jobs back to back, FIFO fills to DEPTH
        busy_len = 10;
        for (int t = 0; t < 5; t++) begin
            set_cmd(t + 1, 2, 3, t * 16, t);
            tick(1);
        end
        chk("burst_level_full", 32'(queue_level), 32'd4);
        chk("burst_ready_low", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        for (int i = 0; i < 400 && jobs_done != 16'd6; i++) tick(1);
        chk("burst_jobs_done", 32'(jobs_done), 32'd6);
        chk("burst_launches", 32'(launches), 32'd6);
        chk("burst_launch_count", 32'(launch_k.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("burst_order_%0d", i), 32'(launch_k[i]), 32'(exp_k[i]));
        end
        chk("burst_gap", 32'(last_gap), 32'd4);
        tick(2);
        chk("burst_idle", 32'(idle), 32'd1);

        // Zero-dimension job is rejected without a launch
        l0 = launches;
        set_cmd(5, 0, 5, 0, 7);
        tick(1);
        cmd_valid = 1'b0;
        tick(1);
        chk("zero_no_launch", 32'(tpu_in_valid), 32'd0);
        tick(1);
        chk("zero_done_valid", 32'(done_valid), 32'd1);
        chk("zero_done_err", 32'(done_err), 32'd1);
        chk("zero_done_tag", 32'(done_tag), 32'd7);
        tick(1);
        chk("zero_jobs_done", 32'(jobs_done), 32'd7);
        tick(1);
        chk("zero_launches", 32'(launches), 32'(l0));
        chk("zero_idle", 32'(idle), 32'd1);

        // Host stalls done_ready: record holds, no launch, queue fills
        done_ready = 1'b0;
        set_cmd(2, 2, 2, 0, 8);
        tick(1);
        cmd_valid = 1'b0;
        for (int i = 0; i < 100 && !done_valid; i++) tick(1);
        chk("stall_done_valid", 32'(done_valid), 32'd1);
        chk("stall_done_tag", 32'(done_tag), 32'd8);
        l1 = launches;
        for (int i = 0; i < 20; i++) begin
            if (i < 4) set_cmd(10 + i, 1, 1, i, 9 + i);
            else cmd_valid = 1'b0;
            tick(1);
            chk("stall_hold_valid", 32'(done_valid), 32'd1);
            chk("stall_hold_tag", 32'(done_tag), 32'd8);
        end
        chk("stall_level", 32'(queue_level), 32'd4);
        chk("stall_ready", 32'(cmd_ready), 32'd0);
        chk("stall_no_launch", 32'(launches), 32'(l1));
        chk("stall_jobs_done", 32'(jobs_done), 32'd7);

        // Flush with 3 queued and 1 in flight
        done_ready = 1'b1;
        tick(1);
        chk("flush_pre_jobs_done", 32'(jobs_done), 32'd8);
        tick(2);
        chk("flush_launch", 32'(tpu_in_valid), 32'd1);
        chk("flush_launch_K", 32'(tpu_K), 32'd10);
        chk("flush_pre_level", 32'(queue_level), 32'd3);
        tick(1);
        flush = 1'b1;
        set_cmd(7, 7, 7, 0, 13);
        #1;
        chk("flush_blocks_push", 32'(cmd_ready), 32'd0);
        tick(1);
        flush     = 1'b0;
        cmd_valid = 1'b0;
        chk("flush_level", 32'(queue_level), 32'd0);
        chk("flush_not_idle", 32'(idle), 32'd0);
        for (int i = 0; i < 100 && !done_valid; i++) tick(1);
        chk("flush_done_valid", 32'(done_valid), 32'd1);
        chk("flush_done_tag", 32'(done_tag), 32'd9);
        chk("flush_done_err", 32'(done_err), 32'd0);
        tick(2);
        chk("flush_idle", 32'(idle), 32'd1);
        chk("flush_launches", 32'(launches), 32'(l1 + 1));
        chk("flush_jobs_done", 32'(jobs_done), 32'd9);

        // Reset in the middle of WAIT_DONE
        busy_len = 40;
        set_cmd(3, 3, 3, 32'h55, 14);
        tick(1);
        cmd_valid = 1'b0;
        for (int i = 0; i < 20 && !tpu_busy; i++) tick(1);
        chk("mid_busy", 32'(tpu_busy), 32'd1);
        set_cmd(4, 4, 4, 0, 15);
        tick(1);
        cmd_valid = 1'b0;
        tick(3);
        chk("mid_level", 32'(queue_level), 32'd1);
        l0 = launches;
        rst_n = 1'b0;
        tick(1);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("mid_rst_in_valid", 32'(tpu_in_valid), 32'd0);
        chk("mid_rst_K", 32'(tpu_K), 32'd0);
        chk("mid_rst_M", 32'(tpu_M), 32'd0);
        chk("mid_rst_N", 32'(tpu_N), 32'd0);
        chk("mid_rst_offset", tpu_offset, 32'd0);
        chk("mid_rst_done_valid", 32'(done_valid), 32'd0);
        chk("mid_rst_done_tag", 32'(done_tag), 32'd0);
        chk("mid_rst_done_err", 32'(done_err), 32'd0);
        chk("mid_rst_level", 32'(queue_level), 32'd0);
        chk("mid_rst_idle", 32'(idle), 32'd1);
        chk("mid_rst_jobs_done", 32'(jobs_done), 32'd0);
        rst_n = 1'b1;
        tick(5);
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_no_record", 32'(done_valid), 32'd0);
        chk("post_rst_no_launch", 32'(launches), 32'(l0));

`ifdef TPU_SCHED_WATCHDOG_EN
        // Watchdog: busy stuck high times out, no relaunch until busy drops
        busy_len = 10;
        set_cmd(6, 6, 6, 0, 2);
        tick(1);
        cmd_valid = 1'b0;
        tick(1);
        chk("wd_launch", 32'(tpu_in_valid), 32'd1);
        force_busy = 1'b1;
        set_cmd(6, 6, 6, 0, 3);
        tick(1);
        cmd_valid = 1'b0;
        tick(63);
        chk("wd_not_yet", 32'(done_valid), 32'd0);
        tick(1);
        chk("wd_done_valid", 32'(done_valid), 32'd1);
        chk("wd_done_err", 32'(done_err), 32'd1);
        chk("wd_done_tag", 32'(done_tag), 32'd2);
        l0 = launches;
        tick(20);
        chk("wd_no_relaunch", 32'(launches), 32'(l0));
        force_busy = 1'b0;
        for (int i = 0; i < 50 && launches == l0; i++) tick(1);
        chk("wd_relaunch", 32'(launches), 32'(l0 + 1));
        tick(30);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tpu_job_scheduler.md
# tpu_job_scheduler

Job scheduler in front of the TPU matrix-multiply core. Accepts GEMM job descriptors (K, M, N, input offset, tag) from the host-side control path, buffers them in a small FIFO, and launches them one at a time on the TPU. It monitors `busy` for start and completion, and returns a tagged completion record to the host. It sits between the CFU command decoder and the TPU's `in_valid`/`busy` interface; the A/B/C buffers are not touched.

## Interface
- `DEPTH`, 4 — job FIFO entries (power of two, ≥2).
- `TIMEOUT_W`, 20 — watchdog counter width (used only with the watchdog compiled in).

- `clk` in 1 — single clock.
- `rst_n` in 1 — reset, synchronous, active-low.
- `cmd_valid` in 1 — job descriptor valid.
- `cmd_ready` out 1 — FIFO can accept; `!full && !flush`.
- `cmd_K` in 10, `cmd_M` in 13, `cmd_N` in 9 — GEMM dimensions.
- `cmd_offset` in 32 — input offset for the job.
- `cmd_tag` in 4 — host job tag, returned on completion.
- `flush` in 1 — discard all queued (not in-flight) jobs.
- `tpu_in_valid` out 1 — one-cycle launch pulse to the TPU.
- `tpu_K` out 10, `tpu_M` out 13, `tpu_N` out 9, `tpu_offset` out 32 — registered job fields, stable from launch until the next launch.
- `tpu_busy` in 1 — TPU busy.
- `done_valid` out 1 — completion record valid.
- `done_ready` in 1 — host accepts the record.
- `done_tag` out 4 — tag of the completed job.
- `done_err` out 1 — 1 = job rejected or timed out.
- `queue_level` out $clog2(DEPTH)+1 — number of queued jobs.
- `idle` out 1 — FIFO empty and state IDLE.
- `jobs_done` out 16 — completion counter.

## Operation
- FIFO push on `cmd_valid && cmd_ready`. No push/pop bypass: `cmd_ready` depends only on the occupancy count and `flush`.
- `flush` clears the occupancy count and pointers in that cycle. An in-flight job continues. A push in the same cycle is blocked because `cmd_ready` is 0.
- FSM states: IDLE, LAUNCH, WAIT_START, WAIT_DONE, REPORT, GAP.
  - IDLE: if the FIFO is non-empty, pop the head into the job registers → LAUNCH.
  - LAUNCH: if K, M or N is 0, do not pulse; set err=1 → REPORT. Otherwise `tpu_in_valid`=1 for this cycle only → WAIT_START.
  - WAIT_START: `tpu_busy`==1 → WAIT_DONE.
  - WAIT_DONE: `tpu_busy`==0 → REPORT, err=0.
  - REPORT: hold `done_valid`=1 with stable `done_tag`/`done_err` until `done_ready`. On the handshake, `jobs_done`+1 (wraps 0xFFFF→0), then → GAP.
  - GAP: one cycle so the TPU returns to its idle state → IDLE.
- `tpu_in_valid` is never asserted outside LAUNCH. At most one job is in flight.
- Reset values: `cmd_ready`=0 during reset and 1 after; `tpu_in_valid`=0; `tpu_K/M/N/offset`=0; `done_valid`=0; `done_tag`=0; `done_err`=0; `queue_level`=0; `idle`=1; `jobs_done`=0; state IDLE. Reset mid-job drops the job and all queued entries, with no completion record; the TPU shares `rst_n`.

## Timing
- Job accepted in cycle N with the scheduler idle and the FIFO empty: pop at the end of N+1, `tpu_in_valid`=1 in cycle N+2.
- TPU asserts `busy` in the cycle after `in_valid`, so WAIT_START normally lasts 1 cycle.
- `busy` falls in cycle B: `done_valid`=1 in B+1.
- Handshake in cycle H: GAP in H+1, IDLE in H+2, next `tpu_in_valid` in H+3 if queued.
- Back-to-back overhead between jobs: 4 cycles plus host `done_ready` latency.
- A held `done_valid` stalls scheduling. The FIFO keeps accepting until full.

## Configuration
- `TPU_SCHED_WATCHDOG_EN` defined:
  - A TIMEOUT_W-bit counter clears on entry to WAIT_START and counts in WAIT_START/WAIT_DONE.
  - On reaching all-ones → REPORT with `done_err`=1.
  - The scheduler then ignores `tpu_busy` until it reads 0 in GAP; GAP extends while `tpu_busy`=1.
- Not defined: no counter. The scheduler waits indefinitely, and `done_err` is raised only for zero-dimension jobs.

## Test plan
- Single job K=16, M=8, N=8, offset=128, tag=3; TPU model busy 40 cycles → `tpu_in_valid` at N+2, fields stable; `done_valid` one cycle after busy falls, tag=3, err=0; `jobs_done`=1.
- Push 5 jobs with DEPTH=4 while the first is in flight → `cmd_ready`=0 at level 4; jobs launch in tag order 0..4; exactly one `in_valid` per job; 4-cycle gap when `done_ready` is tied 1.
- Job with M=0, tag=7 → no `tpu_in_valid`; `done_valid` with err=1, tag=7 two cycles after pop.
- Hold `done_ready`=0 for 20 cycles → `done_valid`/tag stable; no new launch; queue fills; `jobs_done` unchanged until the handshake.
- `flush` with 3 queued and 1 in flight → `queue_level`=0 next cycle; in-flight job still reports; `idle`=1 after GAP. Separately, `rst_n`=0 mid-WAIT_DONE → all outputs at reset values the next cycle.
- With `TPU_SCHED_WATCHDOG_EN` and TIMEOUT_W=6, `busy` stuck high → err=1 after 63 cycles; no relaunch until busy=0.
